// File: rtl/uart_ctrl_pkg.sv
// rtl/uart_ctrl_pkg.sv - shared types and defaults for the UART-to-accelerator sequencer
package uart_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        START = 2'd2,
        RUN   = 2'd3
    } state_e;

    localparam int DEF_NUM_PIXELS  = 784;
    localparam int DEF_ADDR_W      = 10;
    localparam int DEF_TIMEOUT_CYC = 200000;
    localparam int DEF_CLS_W       = 4;

endpackage

// File: rtl/byte_gap_timer.sv
// rtl/byte_gap_timer.sv - counts idle cycles between received bytes, pulses expired at the limit
module byte_gap_timer #(
    parameter int TIMEOUT_CYC = 200000
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Fires on the cycle that would be the TIMEOUT_CYC-th idle one; a byte that cycle suppresses it.
    assign expired = enable && !clear && (cnt_q == LIMIT);

    always_comb begin
        cnt_d = cnt_q;
        if (clear || !enable || expired) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_inference_ctrl.sv
// rtl/uart_inference_ctrl.sv - loads one UART image into ifmap SRAM, starts the core, latches the class
module uart_inference_ctrl
    import uart_ctrl_pkg::*;
#(
    parameter int NUM_PIXELS  = DEF_NUM_PIXELS,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    parameter int CLS_W       = DEF_CLS_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              sram_wen,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [7:0]        sram_wdata,
    output logic              accel_start,
    input  logic              accel_done,
    input  logic [CLS_W-1:0]  accel_class,
    output logic [CLS_W-1:0]  result,
    output logic              result_valid,
    output logic              busy,
    output logic              err_timeout,
    output logic              err_overrun
);

    localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(NUM_PIXELS - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pix_q, pix_d;
    logic              wen_q, wen_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic              start_q, start_d;
    logic [CLS_W-1:0]  result_q, result_d;
    logic              rvalid_q, rvalid_d;
    logic              busy_q, busy_d;
    logic              err_to_q, err_to_d;
    logic              err_ov_q, err_ov_d;
    logic              gap_expired;

    byte_gap_timer #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_gap_timer (
        .clock  (clock),
        .reset  (reset),
        .clear  (rx_valid || (state_q != LOAD)),
        .enable (state_q == LOAD),
        .expired(gap_expired)
    );

    always_comb begin
        state_d  = state_q;
        pix_d    = pix_q;
        wen_d    = 1'b0;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        start_d  = 1'b0;
        result_d = result_q;
        rvalid_d = rvalid_q;
        err_to_d = err_to_q;
        err_ov_d = err_ov_q;

        case (state_q)
            IDLE: begin
                if (rx_valid) begin
                    wen_d    = 1'b1;
                    addr_d   = '0;
                    wdata_d  = rx_data;
                    rvalid_d = 1'b0;
                    if (NUM_PIXELS == 1) begin
                        state_d = START;
                        pix_d   = '0;
                    end else begin
                        state_d = LOAD;
                        pix_d   = ADDR_W'(1);
                    end
                end
            end
            LOAD: begin
                if (rx_valid) begin
                    wen_d   = 1'b1;
                    addr_d  = pix_q;
                    wdata_d = rx_data;
                    if (pix_q == LAST_PIX) begin
                        state_d = START;
                        pix_d   = '0;
                    end else begin
                        pix_d = pix_q + ADDR_W'(1);
                    end
                end else if (gap_expired) begin
                    state_d  = IDLE;
                    pix_d    = '0;
                    err_to_d = 1'b1;
                end
            end
            START: begin
                // Entered the cycle after the last write is visible, so the SRAM already holds it.
                start_d = 1'b1;
                state_d = RUN;
                if (rx_valid) begin
                    err_ov_d = 1'b1;
                end
            end
            RUN: begin
                if (rx_valid) begin
                    err_ov_d = 1'b1;
                end
                if (accel_done) begin
                    result_d = accel_class;
                    rvalid_d = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            pix_q    <= '0;
            wen_q    <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            start_q  <= 1'b0;
            result_q <= '0;
            rvalid_q <= 1'b0;
            busy_q   <= 1'b0;
            err_to_q <= 1'b0;
            err_ov_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pix_q    <= pix_d;
            wen_q    <= wen_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            start_q  <= start_d;
            result_q <= result_d;
            rvalid_q <= rvalid_d;
            busy_q   <= busy_d;
            err_to_q <= err_to_d;
            err_ov_q <= err_ov_d;
        end
    end

    assign sram_wen     = wen_q;
    assign sram_addr    = addr_q;
    assign sram_wdata   = wdata_q;
    assign accel_start  = start_q;
    assign result       = result_q;
    assign result_valid = rvalid_q;
    assign busy         = busy_q;
    assign err_timeout  = err_to_q;
    assign err_overrun  = err_ov_q;

endmodule

// File: tb/tb_uart_inference_ctrl.sv
// tb/tb_uart_inference_ctrl.sv - directed self-checking bench for uart_inference_ctrl
module tb_uart_inference_ctrl;

    localparam int NP = 784;
    localparam int AW = 10;
    localparam int TO = 100;
    localparam int CW = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          rx_valid = 1'b0;
    logic [7:0]    rx_data = '0;
    logic          accel_done = 1'b0;
    logic [CW-1:0] accel_class = '0;
    logic          sram_wen;
    logic [AW-1:0] sram_addr;
    logic [7:0]    sram_wdata;
    logic          accel_start;
    logic [CW-1:0] result;
    logic          result_valid;
    logic          busy;
    logic          err_timeout;
    logic          err_overrun;

    int n_tests = 0;
    int n_fail  = 0;
    int wen_cnt = 0;
    int start_cnt = 0;

    always #5 clock = ~clock;

    uart_inference_ctrl #(
        .NUM_PIXELS (NP),
        .ADDR_W     (AW),
        .TIMEOUT_CYC(TO),
        .CLS_W      (CW)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .sram_wen    (sram_wen),
        .sram_addr   (sram_addr),
        .sram_wdata  (sram_wdata),
        .accel_start (accel_start),
        .accel_done  (accel_done),
        .accel_class (accel_class),
        .result      (result),
        .result_valid(result_valid),
        .busy        (busy),
        .err_timeout (err_timeout),
        .err_overrun (err_overrun)
    );

    always @(posedge clock) begin
        #1;
        if (sram_wen) wen_cnt++;
        if (accel_start) start_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic exp_wen, input int exp_addr);
        rx_valid = 1'b1;
        rx_data  = d;
        @(negedge clock);
        rx_valid = 1'b0;
        check_eq("wen", sram_wen, exp_wen);
        if (exp_wen) begin
            check_eq("addr", sram_addr, exp_addr);
            check_eq("wdata", sram_wdata, d);
        end
    endtask

    task automatic load_image(input int off, input int gap_at, input int gap_len);
        int s0;
        int w0;
        s0 = start_cnt;
        w0 = wen_cnt;
        for (int i = 0; i < NP; i++) begin
            send_byte(8'((i + off) % 256), 1'b1, i);
            if (i == gap_at) idle(gap_len);
            if (i == NP / 2) check_eq("busy_load", busy, 1);
        end
        check_eq("start_early", accel_start, 0);
        @(negedge clock);
        check_eq("start_pulse", accel_start, 1);
        check_eq("busy_start", busy, 1);
        @(negedge clock);
        check_eq("start_off", accel_start, 0);
        check_eq("start_count", start_cnt - s0, 1);
        check_eq("wen_count", wen_cnt - w0, NP);
    endtask

    task automatic classify(input logic [CW-1:0] cls);
        accel_class = cls;
        accel_done  = 1'b1;
        @(negedge clock);
        accel_done = 1'b0;
        check_eq("result", result, cls);
        check_eq("result_valid", result_valid, 1);
        check_eq("busy_done", busy, 0);
    endtask

    initial begin
        int s0;

        idle(2);
        check_eq("rst_wen", sram_wen, 0);
        check_eq("rst_addr", sram_addr, 0);
        check_eq("rst_start", accel_start, 0);
        check_eq("rst_result", result, 0);
        check_eq("rst_rvalid", result_valid, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_err_to", err_timeout, 0);
        check_eq("rst_err_ov", err_overrun, 0);
        reset = 1'b0;
        idle(2);

        // Full image, bytes 0..255 repeating, then classify after ~50 cycles
        load_image(0, -1, 0);
        idle(48);
        classify(4'd7);
        send_byte(8'h11, 1'b1, 0);
        check_eq("rvalid_cleared", result_valid, 0);
        check_eq("busy_new_img", busy, 1);

        // Stall after 10 bytes: abort exactly on the 100th idle cycle
        s0 = start_cnt;
        for (int i = 1; i < 10; i++) send_byte(8'(i + 16), 1'b1, i);
        idle(TO - 1);
        check_eq("busy_pre_to", busy, 1);
        check_eq("err_to_pre", err_timeout, 0);
        idle(1);
        check_eq("busy_post_to", busy, 0);
        check_eq("err_to_set", err_timeout, 1);
        check_eq("no_start_to", start_cnt - s0, 0);
        load_image(5, -1, 0);

        // Overrun during RUN, then a byte coincident with done
        check_eq("err_ov_pre", err_overrun, 0);
        send_byte(8'hAA, 1'b0, 0);
        check_eq("err_ov_run", err_overrun, 1);
        rx_valid    = 1'b1;
        rx_data     = 8'hBB;
        accel_class = 4'd12;
        accel_done  = 1'b1;
        @(negedge clock);
        rx_valid   = 1'b0;
        accel_done = 1'b0;
        check_eq("coinc_wen", sram_wen, 0);
        check_eq("coinc_result", result, 12);
        check_eq("coinc_rvalid", result_valid, 1);
        check_eq("coinc_busy", busy, 0);
        check_eq("coinc_err_ov", err_overrun, 1);
        check_eq("err_to_sticky", err_timeout, 1);
        accel_class = 4'd9;
        accel_done  = 1'b1;
        @(negedge clock);
        accel_done = 1'b0;
        check_eq("idle_done_result", result, 12);
        check_eq("idle_done_busy", busy, 0);

        // Reset in the middle of a load
        for (int i = 0; i < 400; i++) send_byte(8'(i), 1'b1, i);
        #2 reset = 1'b1;
        #1;
        check_eq("mid_rst_wen", sram_wen, 0);
        check_eq("mid_rst_addr", sram_addr, 0);
        check_eq("mid_rst_busy", busy, 0);
        check_eq("mid_rst_result", result, 0);
        check_eq("mid_rst_rvalid", result_valid, 0);
        check_eq("mid_rst_err_to", err_timeout, 0);
        check_eq("mid_rst_err_ov", err_overrun, 0);
        @(negedge clock);
        reset = 1'b0;
        idle(2);
        load_image(100, -1, 0);
        idle(10);
        classify(4'd4);

        // Byte arriving on the would-be timeout cycle keeps the load alive
        load_image(200, 500, TO - 1);
        check_eq("err_to_edge", err_timeout, 0);
        idle(5);
        classify(4'd15);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
